// File: rtl/corr_result_collector.sv
// Round-robin collector for correlator results: masters the register bus to read
// Cnt/Low/High/Status of a ready channel and queues the record in a fall-through FIFO.
module corr_result_collector #(
    parameter int          NCH        = 32,
    parameter logic [31:0] CORR_BASE  = 32'hFE000700,
    parameter logic [31:0] CH_STRIDE  = 32'h10,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [NCH-1:0]  seen,
    output logic            bus_req,
    input  logic            bus_gnt,
    output logic [31:0]     bus_addr,
    output logic            bus_read,
    input  logic [31:0]     bus_rdata,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [100:0]    res_data,
    output logic [3:0]      fifo_level,
    output logic            busy
);

    localparam int         CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RD_CNT  = 3'd2,
        S_RD_LOW  = 3'd3,
        S_RD_HIGH = 3'd4,
        S_RD_STAT = 3'd5,
        S_PUSH    = 3'd6
    } state_t;

    state_t           state_r, state_n_s;
    logic [CHW-1:0]   ch_r, rr_r, clr_ch_r, sel_ch_s, rr_idx_s;
    logic [31:0]      cnt_r, low_r, high_r, base_s;
    logic [NCH-1:0]   hold_r, pending_s, set_mask_s, clr_mask_s;
    logic             clr_v_r, sel_found_s, start_s, push_s, pop_s;
    logic [100:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [3:0]       count_r;

    // Held channels stay masked until their seen flag has had time to drop.
    assign pending_s  = seen & ~hold_r;
    assign set_mask_s = start_s ? (NCH'(1) << sel_ch_s) : '0;
    assign clr_mask_s = clr_v_r ? (NCH'(1) << clr_ch_r) : '0;
    assign base_s     = CORR_BASE + (32'(ch_r) * CH_STRIDE);

    // Round-robin search: first pending channel at or after rr, wrapping.
    always_comb begin
        sel_found_s = 1'b0;
        sel_ch_s    = rr_r;
        rr_idx_s    = rr_r;
        for (int i = 0; i < NCH; i++) begin
            rr_idx_s = rr_r + CHW'(i);
            if (pending_s[rr_idx_s] && !sel_found_s) begin
                sel_found_s = 1'b1;
                sel_ch_s    = rr_idx_s;
            end else begin
                sel_ch_s    = sel_ch_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next state and bus strobes; a read happens only in a granted cycle.
    always_comb begin
        state_n_s = state_r;
        bus_req   = 1'b0;
        bus_read  = 1'b0;
        bus_addr  = 32'h0000_0000;
        start_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (enable && sel_found_s && (count_r < DEPTH_L)) begin
                    start_s   = 1'b1;
                    state_n_s = S_REQ;
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) state_n_s = S_RD_CNT;
                else         state_n_s = S_REQ;
            end
            S_RD_CNT, S_RD_LOW, S_RD_HIGH, S_RD_STAT: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    bus_read = 1'b1;
                    case (state_r)
                        S_RD_CNT:  begin bus_addr = base_s;                state_n_s = S_RD_LOW;  end
                        S_RD_LOW:  begin bus_addr = base_s + 32'h0000_0004; state_n_s = S_RD_HIGH; end
                        S_RD_HIGH: begin bus_addr = base_s + 32'h0000_0008; state_n_s = S_RD_STAT; end
                        default:   begin bus_addr = base_s + 32'h0000_000C; state_n_s = S_PUSH;    end
                    endcase
                end else begin
                    state_n_s = state_r;
                end
            end
            S_PUSH:  state_n_s = S_IDLE;
            default: state_n_s = S_IDLE;
        endcase
    end

    // Channel selection, captured read data, hold mask and rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_r     <= '0;
            rr_r     <= '0;
            cnt_r    <= 32'h0000_0000;
            low_r    <= 32'h0000_0000;
            high_r   <= 32'h0000_0000;
            hold_r   <= '0;
            clr_v_r  <= 1'b0;
            clr_ch_r <= '0;
        end else begin
            hold_r   <= (hold_r | set_mask_s) & ~clr_mask_s;
            clr_v_r  <= bus_read && (state_r == S_RD_STAT);
            clr_ch_r <= ch_r;
            if (start_s) ch_r <= sel_ch_s;
            if (state_r == S_PUSH) rr_r <= ch_r + CHW'(1);
            if (bus_read) begin
                case (state_r)
                    S_RD_CNT:  cnt_r  <= bus_rdata;
                    S_RD_LOW:  low_r  <= bus_rdata;
                    S_RD_HIGH: high_r <= bus_rdata;
                    default:   cnt_r  <= cnt_r;
                endcase
            end
        end
    end

    assign push_s = (state_r == S_PUSH);
    assign pop_s  = res_valid && res_ready;

    // Result FIFO storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {5'(ch_r), cnt_r, high_r, low_r};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign res_valid  = (count_r != 4'd0);
    assign res_data   = mem_r[rd_ptr_r];
    assign fifo_level = count_r;
    assign busy       = (state_r != S_IDLE);

endmodule

// File: tb/tb_corr_result_collector.sv
// Directed bench for corr_result_collector: models the correlator register bus and
// the seen-flag clear that follows a Status read.
module tb_corr_result_collector;

    logic         clk = 1'b0;
    logic         rst_n, enable, bus_gnt, res_ready;
    logic [31:0]  seen;
    logic         bus_req, bus_read, res_valid, busy;
    logic [31:0]  bus_addr, bus_rdata;
    logic [100:0] res_data;
    logic [3:0]   fifo_level;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nlog = 0;
    int          first_valid_cyc = -1;
    logic [31:0] log_addr [64];
    int          log_cyc  [64];
    logic [31:0] clr_a, clr_b;

    corr_result_collector dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .seen(seen),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_read(bus_read),
        .bus_rdata(bus_rdata), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .fifo_level(fifo_level), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [100:0] exp_rec(input int ch);
        logic [31:0] b;
        b = 32'hFE00_0700 + 32'(ch) * 32'h10;
        return {5'(ch), rd_model(b), rd_model(b + 32'h8), rd_model(b + 32'h4)};
    endfunction

    assign bus_rdata = rd_model(bus_addr);

    // One clock: sample at negedge, log reads, then apply the delayed seen clear.
    task automatic step();
        logic [31:0] off;
        @(negedge clk);
        if (res_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus_read === 1'b1) begin
            off = bus_addr - 32'hFE00_0700;
            if (nlog < 64) begin
                log_addr[nlog] = bus_addr;
                log_cyc[nlog]  = cyc;
            end
            nlog++;
            if (off[3:0] == 4'hC) clr_a = clr_a | (32'd1 << off[8:4]);
        end
        @(posedge clk);
        #1;
        cyc++;
        seen  = seen & ~clr_b;
        clr_b = clr_a;
        clr_a = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; seen = 32'd0; bus_gnt = 1'b1; res_ready = 1'b0;
        clr_a = 32'd0; clr_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b1;
        nlog = 0;
        first_valid_cyc = -1;
    endtask

    task automatic pop_expect(input int ch, input string name);
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL %s valid: got %b, expected 1", name, res_valid); end
        checks++;
        if (res_data !== exp_rec(ch)) begin errors++; $display("FAIL %s data: got %h, expected %h", name, res_data, exp_rec(ch)); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus_req, bus_read, res_valid, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b, expected 0000", {bus_req, bus_read, res_valid, busy}); end
        checks++;
        if (bus_addr !== 32'd0 || fifo_level !== 4'd0) begin errors++; $display("FAIL reset_addr_level: got %h/%0d, expected 0/0", bus_addr, fifo_level); end
        checks++;
        if (res_data !== 101'd0) begin errors++; $display("FAIL reset_data: got %h, expected 0", res_data); end
    endtask

    task automatic test_single();
        logic [100:0] exp;
        do_reset();
        seen = 32'h0000_0001;
        repeat (12) step();
        exp = {5'd0, 32'h0700_F8FF, 32'h0708_F8F7, 32'h0704_F8FB};
        checks++;
        if (nlog !== 4) begin errors++; $display("FAIL single_nreads: got %0d, expected 4", nlog); end
        checks++;
        if (log_addr[0] !== 32'hFE00_0700 || log_addr[1] !== 32'hFE00_0704 ||
            log_addr[2] !== 32'hFE00_0708 || log_addr[3] !== 32'hFE00_070C) begin
            errors++; $display("FAIL single_addrs: got %h %h %h %h, expected FE000700/704/708/70C", log_addr[0], log_addr[1], log_addr[2], log_addr[3]);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (log_cyc[i] !== log_cyc[0] + i) begin errors++; $display("FAIL single_consecutive[%0d]: got cycle %0d, expected %0d", i, log_cyc[i], log_cyc[0] + i); end
        end
        checks++;
        if (first_valid_cyc !== log_cyc[0] + 5) begin errors++; $display("FAIL single_latency: got cycle %0d, expected %0d", first_valid_cyc, log_cyc[0] + 5); end
        checks++;
        if (fifo_level !== 4'd1 || busy !== 1'b0) begin errors++; $display("FAIL single_level_busy: got %0d/%b, expected 1/0", fifo_level, busy); end
        checks++;
        if (res_data !== exp) begin errors++; $display("FAIL single_record: got %h, expected %h", res_data, exp); end
    endtask

    task automatic test_round_robin();
        do_reset();
        seen = 32'h8000_0005;
        repeat (30) step();
        checks++;
        if (nlog !== 12) begin errors++; $display("FAIL rr_nreads: got %0d, expected 12", nlog); end
        checks++;
        if (log_addr[3] !== 32'hFE00_070C || log_addr[7] !== 32'hFE00_072C || log_addr[11] !== 32'hFE00_08FC) begin
            errors++; $display("FAIL rr_order: got %h %h %h, expected FE00070C FE00072C FE0008FC", log_addr[3], log_addr[7], log_addr[11]);
        end
        pop_expect(0, "rr_pop0");
        pop_expect(2, "rr_pop2");
        pop_expect(31, "rr_pop31");
        checks++;
        if (nlog !== 12 || busy !== 1'b0) begin errors++; $display("FAIL rr_no_reserve: got %0d reads busy=%b, expected 12/0", nlog, busy); end
        seen = 32'h0000_0009;
        repeat (20) step();
        checks++;
        if (log_addr[12] !== 32'hFE00_0700 || log_addr[16] !== 32'hFE00_0730) begin
            errors++; $display("FAIL rr_wrap: got %h %h, expected FE000700 FE000730", log_addr[12], log_addr[16]);
        end
    endtask

    task automatic test_gnt_stall();
        int i;
        do_reset();
        seen = 32'h0000_0020;
        for (i = 0; i < 20 && nlog < 1; i++) step();
        checks++;
        if (nlog < 1) begin errors++; $display("FAIL stall_timeout: got %0d reads, expected 1", nlog); end
        bus_gnt = 1'b0;
        #1;
        checks++;
        if (bus_read !== 1'b0 || bus_addr !== 32'd0 || bus_req !== 1'b1) begin
            errors++; $display("FAIL stall_bus: got read=%b addr=%h req=%b, expected 0/0/1", bus_read, bus_addr, bus_req);
        end
        step();
        step();
        bus_gnt = 1'b1;
        repeat (12) step();
        checks++;
        if (nlog !== 4 || log_addr[1] !== 32'hFE00_0754 || log_addr[2] !== 32'hFE00_0758) begin
            errors++; $display("FAIL stall_reads: got %0d reads low=%h high=%h, expected 4/FE000754/FE000758", nlog, log_addr[1], log_addr[2]);
        end
        checks++;
        if (log_cyc[1] !== log_cyc[0] + 3 || log_cyc[3] !== log_cyc[0] + 5) begin
            errors++; $display("FAIL stall_timing: got %0d/%0d, expected %0d/%0d", log_cyc[1], log_cyc[3], log_cyc[0] + 3, log_cyc[0] + 5);
        end
        pop_expect(5, "stall_pop5");
    endtask

    task automatic test_fifo_full();
        do_reset();
        seen = 32'h0000_01FF;
        repeat (80) step();
        checks++;
        if (fifo_level !== 4'd8 || busy !== 1'b0 || nlog !== 32) begin
            errors++; $display("FAIL full_hold: got level=%0d busy=%b reads=%0d, expected 8/0/32", fifo_level, busy, nlog);
        end
        pop_expect(0, "full_pop0");
        repeat (15) step();
        checks++;
        if (fifo_level !== 4'd8 || nlog !== 36 || log_addr[32] !== 32'hFE00_0780) begin
            errors++; $display("FAIL full_ninth: got level=%0d reads=%0d addr=%h, expected 8/36/FE000780", fifo_level, nlog, log_addr[32]);
        end
        for (int c = 1; c <= 8; c++) pop_expect(c, "full_drain");
        checks++;
        if (fifo_level !== 4'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %0d/%b, expected 0/0", fifo_level, res_valid); end
    endtask

    task automatic test_reset_mid();
        int i;
        do_reset();
        seen = 32'h0000_0008;
        for (i = 0; i < 20 && nlog < 2; i++) step();
        checks++;
        if (bus_read !== 1'b1 || bus_addr !== 32'hFE00_0738) begin errors++; $display("FAIL rstmid_high: got %b/%h, expected 1/FE000738", bus_read, bus_addr); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_req, bus_read, busy, res_valid} !== 4'b0000 || bus_addr !== 32'd0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL rstmid_outputs: got %b addr=%h level=%0d, expected 0000/0/0", {bus_req, bus_read, busy, res_valid}, bus_addr, fifo_level);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nlog = 0;
        repeat (15) step();
        checks++;
        if (nlog !== 4 || log_addr[0] !== 32'hFE00_0730 || log_addr[3] !== 32'hFE00_073C) begin
            errors++; $display("FAIL rstmid_reserve: got %0d reads %h..%h, expected 4 FE000730..FE00073C", nlog, log_addr[0], log_addr[3]);
        end
        pop_expect(3, "rstmid_pop3");
    endtask

    task automatic test_no_duplicate();
        do_reset();
        seen = 32'h0000_0080;
        repeat (25) step();
        checks++;
        if (nlog !== 4 || fifo_level !== 4'd1) begin errors++; $display("FAIL nodup: got %0d reads level=%0d, expected 4/1", nlog, fifo_level); end
        pop_expect(7, "nodup_pop7");
    endtask

    task automatic test_enable();
        do_reset();
        enable = 1'b0;
        seen = 32'h0000_0002;
        repeat (10) step();
        checks++;
        if (busy !== 1'b0 || nlog !== 0) begin errors++; $display("FAIL en_off: got busy=%b reads=%0d, expected 0/0", busy, nlog); end
        enable = 1'b1;
        repeat (3) step();
        enable = 1'b0;
        repeat (10) step();
        checks++;
        if (nlog !== 4 || fifo_level !== 4'd1) begin errors++; $display("FAIL en_complete: got %0d reads level=%0d, expected 4/1", nlog, fifo_level); end
        seen = seen | 32'h0000_0010;
        repeat (10) step();
        checks++;
        if (nlog !== 4 || busy !== 1'b0) begin errors++; $display("FAIL en_nostart: got %0d reads busy=%b, expected 4/0", nlog, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_gnt_stall();
        test_fifo_full();
        test_reset_mid();
        test_no_duplicate();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
